// File: rtl/shift_cmd_pipe.sv
// -----------------------------------------------------------------------------
// shift_cmd_pipe
//   Two-stage valid/ready wrapper around an external combinational barrel
//   shifter. Stage S1 holds the accepted command and drives the shifter
//   inputs. Stage S2 registers the shifter result for the consumer. The block
//   also keeps a 16-bit count of delivered results and a sticky overflow flag.
//
// Ports
//   clk_in         sole clock, rising edge
//   rst_in         synchronous active-high reset
//   cmd_valid_in   command offered
//   cmd_ready_out  command can be taken this cycle
//   x_in/s_in/op_in      command operand, shift amount, opcode
//   sh_x_out/sh_s_out/sh_op_out  registered shifter inputs (from S1)
//   sh_y_in/sh_zf_in/sh_vf_in    combinational shifter result
//   res_valid_out  result available
//   res_ready_in   consumer takes the result this cycle
//   y_out/zf_out/vf_out  registered result (from S2)
//   clr_in         synchronous clear of the statistics
//   op_count_out   number of results delivered, wraps at 16 bits
//   vf_sticky_out  set by any delivered result with overflow
// -----------------------------------------------------------------------------
module shift_cmd_pipe #(
  parameter int D_SIZE = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       cmd_valid_in,
  output logic                       cmd_ready_out,
  input  logic [D_SIZE-1:0]          x_in,
  input  logic [$clog2(D_SIZE)-1:0]  s_in,
  input  logic [2:0]                 op_in,
  output logic [D_SIZE-1:0]          sh_x_out,
  output logic [$clog2(D_SIZE)-1:0]  sh_s_out,
  output logic [2:0]                 sh_op_out,
  input  logic [D_SIZE-1:0]          sh_y_in,
  input  logic                       sh_zf_in,
  input  logic                       sh_vf_in,
  output logic                       res_valid_out,
  input  logic                       res_ready_in,
  output logic [D_SIZE-1:0]          y_out,
  output logic                       zf_out,
  output logic                       vf_out,
  input  logic                       clr_in,
  output logic [15:0]                op_count_out,
  output logic                       vf_sticky_out
);

  localparam int S_W = $clog2(D_SIZE);

  // S1: accepted command
  logic              s1_v_q,  s1_v_d;
  logic [D_SIZE-1:0] s1_x_q,  s1_x_d;
  logic [S_W-1:0]    s1_s_q,  s1_s_d;
  logic [2:0]        s1_op_q, s1_op_d;

  // S2: registered shifter result
  logic              s2_v_q,  s2_v_d;
  logic [D_SIZE-1:0] s2_y_q,  s2_y_d;
  logic              s2_zf_q, s2_zf_d;
  logic              s2_vf_q, s2_vf_d;

  // Statistics
  logic [15:0]       cnt_q,    cnt_d;
  logic              sticky_q, sticky_d;

  logic s2_adv;
  logic accept;
  logic xfer;

  // S1 may move into S2 when S2 is empty or is being drained this cycle; a
  // new command fits whenever S1 is empty or S1 is moving on. This chains the
  // ready path combinationally so the pipe sustains one command per cycle.
  assign s2_adv        = s1_v_q & (~s2_v_q | res_ready_in);
  assign cmd_ready_out = ~s1_v_q | s2_adv;
  assign accept        = cmd_valid_in & cmd_ready_out;
  assign xfer          = s2_v_q & res_ready_in;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    s1_v_d   = s1_v_q;
    s1_x_d   = s1_x_q;
    s1_s_d   = s1_s_q;
    s1_op_d  = s1_op_q;
    s2_v_d   = s2_v_q;
    s2_y_d   = s2_y_q;
    s2_zf_d  = s2_zf_q;
    s2_vf_d  = s2_vf_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;

    // S1 data only changes on accept, so the shifter inputs stay stable
    // while a stalled command waits.
    if (accept) begin
      s1_v_d  = 1'b1;
      s1_x_d  = x_in;
      s1_s_d  = s_in;
      s1_op_d = op_in;
    end else if (s2_adv) begin
      s1_v_d  = 1'b0;
    end

    if (s2_adv) begin
      s2_v_d  = 1'b1;
      s2_y_d  = sh_y_in;
      s2_zf_d = sh_zf_in;
      s2_vf_d = sh_vf_in;
    end else if (xfer) begin
      s2_v_d  = 1'b0;
    end

    // A transfer in the same cycle as a clear counts as the first event after
    // the clear, so it wins over the clear.
    if (xfer) begin
      cnt_d    = clr_in ? 16'd1 : cnt_q + 16'd1;
      sticky_d = clr_in ? s2_vf_q : (sticky_q | s2_vf_q);
    end else if (clr_in) begin
      cnt_d    = 16'd0;
      sticky_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_v_q   <= 1'b0;
      s1_x_q   <= '0;
      s1_s_q   <= '0;
      s1_op_q  <= '0;
      s2_v_q   <= 1'b0;
      s2_y_q   <= '0;
      s2_zf_q  <= 1'b0;
      s2_vf_q  <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_x_q   <= s1_x_d;
      s1_s_q   <= s1_s_d;
      s1_op_q  <= s1_op_d;
      s2_v_q   <= s2_v_d;
      s2_y_q   <= s2_y_d;
      s2_zf_q  <= s2_zf_d;
      s2_vf_q  <= s2_vf_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign sh_x_out      = s1_x_q;
  assign sh_s_out      = s1_s_q;
  assign sh_op_out     = s1_op_q;
  assign res_valid_out = s2_v_q;
  assign y_out         = s2_y_q;
  assign zf_out        = s2_zf_q;
  assign vf_out        = s2_vf_q;
  assign op_count_out  = cnt_q;
  assign vf_sticky_out = sticky_q;

endmodule

// File: tb/tb_shift_cmd_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_cmd_pipe
//   Directed bench for shift_cmd_pipe with D_SIZE=8. The external shifter is
//   modelled as a left shift; vf reports bits shifted out, zf a zero result.
// -----------------------------------------------------------------------------
module tb_shift_cmd_pipe;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [7:0]  x_in;
  logic [2:0]  s_in;
  logic [2:0]  op_in;
  logic [7:0]  sh_x_out;
  logic [2:0]  sh_s_out;
  logic [2:0]  sh_op_out;
  logic [7:0]  sh_y_in;
  logic        sh_zf_in;
  logic        sh_vf_in;
  logic        res_valid_out;
  logic        res_ready_in;
  logic [7:0]  y_out;
  logic        zf_out;
  logic        vf_out;
  logic        clr_in;
  logic [15:0] op_count_out;
  logic        vf_sticky_out;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] wide;
  assign wide     = {8'h00, sh_x_out} << sh_s_out;
  assign sh_y_in  = wide[7:0];
  assign sh_vf_in = |wide[15:8];
  assign sh_zf_in = (wide[7:0] == 8'h00);

  shift_cmd_pipe #(.D_SIZE(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .x_in(x_in), .s_in(s_in), .op_in(op_in),
    .sh_x_out(sh_x_out), .sh_s_out(sh_s_out), .sh_op_out(sh_op_out),
    .sh_y_in(sh_y_in), .sh_zf_in(sh_zf_in), .sh_vf_in(sh_vf_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .y_out(y_out), .zf_out(zf_out), .vf_out(vf_out),
    .clr_in(clr_in), .op_count_out(op_count_out), .vf_sticky_out(vf_sticky_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] x, input logic [2:0] s, input logic [2:0] op);
    cmd_valid_in = v; x_in = x; s_in = s; op_in = op;
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; clr_in = 1'b0; res_ready_in = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 3'd0);
    step(); step();
    rst_in = 1'b0;
    #1;
    n_cmp++; if (res_valid_out !== 1'b0) begin n_mis++; $display("FAIL reset_res_valid: got %b want 0", res_valid_out); end
    n_cmp++; if (cmd_ready_out !== 1'b1) begin n_mis++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_out); end
    n_cmp++; if (op_count_out !== 16'h0000) begin n_mis++; $display("FAIL reset_count: got %h want 0000", op_count_out); end
    n_cmp++; if (vf_sticky_out !== 1'b0) begin n_mis++; $display("FAIL reset_sticky: got %b want 0", vf_sticky_out); end
    n_cmp++; if (y_out !== 8'h00) begin n_mis++; $display("FAIL reset_y: got %h want 00", y_out); end
  endtask

  task automatic test_single();
    res_ready_in = 1'b1;
    drive(1'b1, 8'h0F, 3'd2, 3'd5);
    n_cmp++; if (cmd_ready_out !== 1'b1) begin n_mis++; $display("FAIL single_ready: got %b want 1", cmd_ready_out); end
    step();
    drive(1'b0, 8'hAA, 3'd7, 3'd1);
    n_cmp++; if (sh_x_out !== 8'h0F) begin n_mis++; $display("FAIL single_sh_x: got %h want 0f", sh_x_out); end
    n_cmp++; if (sh_s_out !== 3'd2) begin n_mis++; $display("FAIL single_sh_s: got %0d want 2", sh_s_out); end
    n_cmp++; if (sh_op_out !== 3'd5) begin n_mis++; $display("FAIL single_sh_op: got %0d want 5", sh_op_out); end
    n_cmp++; if (res_valid_out !== 1'b0) begin n_mis++; $display("FAIL single_early_valid: got %b want 0", res_valid_out); end
    step();
    n_cmp++; if (res_valid_out !== 1'b1) begin n_mis++; $display("FAIL single_valid: got %b want 1", res_valid_out); end
    n_cmp++; if (y_out !== 8'h3C) begin n_mis++; $display("FAIL single_y: got %h want 3c", y_out); end
    n_cmp++; if (op_count_out !== 16'd0) begin n_mis++; $display("FAIL single_count_pre: got %0d want 0", op_count_out); end
    step();
    n_cmp++; if (op_count_out !== 16'd1) begin n_mis++; $display("FAIL single_count: got %0d want 1", op_count_out); end
    n_cmp++; if (res_valid_out !== 1'b0) begin n_mis++; $display("FAIL single_drained: got %b want 0", res_valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs [4] = '{8'h01, 8'h11, 8'h35, 8'h03};
    logic [2:0] ss [4] = '{3'd1, 3'd3, 3'd0, 3'd4};
    logic [7:0] ex [4] = '{8'h02, 8'h88, 8'h35, 8'h30};
    res_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, xs[i], ss[i], 3'(i));
      n_cmp++; if (cmd_ready_out !== 1'b1) begin n_mis++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, cmd_ready_out); end
      step();
      if (i > 0) begin
        n_cmp++; if (res_valid_out !== 1'b1 || y_out !== ex[i-1]) begin n_mis++; $display("FAIL b2b_y[%0d]: got v=%b y=%h want v=1 y=%h", i-1, res_valid_out, y_out, ex[i-1]); end
      end
    end
    drive(1'b0, 8'h00, 3'd0, 3'd0);
    step();
    n_cmp++; if (res_valid_out !== 1'b1 || y_out !== ex[3]) begin n_mis++; $display("FAIL b2b_y[3]: got v=%b y=%h want v=1 y=%h", res_valid_out, y_out, ex[3]); end
    step();
    n_cmp++; if (op_count_out !== 16'd5) begin n_mis++; $display("FAIL b2b_count: got %0d want 5", op_count_out); end
    n_cmp++; if (res_valid_out !== 1'b0) begin n_mis++; $display("FAIL b2b_drained: got %b want 0", res_valid_out); end
  endtask

  task automatic test_backpressure();
    res_ready_in = 1'b0;
    drive(1'b1, 8'h03, 3'd1, 3'd0);
    n_cmp++; if (cmd_ready_out !== 1'b1) begin n_mis++; $display("FAIL bp_ready_a: got %b want 1", cmd_ready_out); end
    step();
    drive(1'b1, 8'h21, 3'd2, 3'd0);
    n_cmp++; if (cmd_ready_out !== 1'b1) begin n_mis++; $display("FAIL bp_ready_b: got %b want 1", cmd_ready_out); end
    step();
    drive(1'b1, 8'h07, 3'd3, 3'd0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (cmd_ready_out !== 1'b0) begin n_mis++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", k, cmd_ready_out); end
      n_cmp++; if (res_valid_out !== 1'b1 || y_out !== 8'h06) begin n_mis++; $display("FAIL bp_hold_y[%0d]: got v=%b y=%h want v=1 y=06", k, res_valid_out, y_out); end
      n_cmp++; if (sh_x_out !== 8'h21) begin n_mis++; $display("FAIL bp_hold_sh_x[%0d]: got %h want 21", k, sh_x_out); end
      if (k < 3) step();
    end
    res_ready_in = 1'b1;
    #1;
    n_cmp++; if (cmd_ready_out !== 1'b1) begin n_mis++; $display("FAIL bp_release_ready: got %b want 1", cmd_ready_out); end
    step();
    drive(1'b0, 8'h00, 3'd0, 3'd0);
    n_cmp++; if (res_valid_out !== 1'b1 || y_out !== 8'h84) begin n_mis++; $display("FAIL bp_y_b: got v=%b y=%h want v=1 y=84", res_valid_out, y_out); end
    step();
    n_cmp++; if (res_valid_out !== 1'b1 || y_out !== 8'h38) begin n_mis++; $display("FAIL bp_y_c: got v=%b y=%h want v=1 y=38", res_valid_out, y_out); end
    step();
    n_cmp++; if (res_valid_out !== 1'b0) begin n_mis++; $display("FAIL bp_drained: got %b want 0", res_valid_out); end
    n_cmp++; if (op_count_out !== 16'd8) begin n_mis++; $display("FAIL bp_count: got %0d want 8", op_count_out); end
  endtask

  task automatic test_sticky_clear();
    n_cmp++; if (vf_sticky_out !== 1'b0) begin n_mis++; $display("FAIL sticky_initial: got %b want 0", vf_sticky_out); end
    res_ready_in = 1'b1;
    drive(1'b1, 8'h80, 3'd1, 3'd0);
    step();
    drive(1'b0, 8'h00, 3'd0, 3'd0);
    step();
    n_cmp++; if (y_out !== 8'h00 || vf_out !== 1'b1 || zf_out !== 1'b1) begin n_mis++; $display("FAIL sticky_result: got y=%h vf=%b zf=%b want y=00 vf=1 zf=1", y_out, vf_out, zf_out); end
    n_cmp++; if (vf_sticky_out !== 1'b0) begin n_mis++; $display("FAIL sticky_before_xfer: got %b want 0", vf_sticky_out); end
    step();
    n_cmp++; if (vf_sticky_out !== 1'b1) begin n_mis++; $display("FAIL sticky_set: got %b want 1", vf_sticky_out); end
    n_cmp++; if (op_count_out !== 16'd9) begin n_mis++; $display("FAIL sticky_count: got %0d want 9", op_count_out); end
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    n_cmp++; if (vf_sticky_out !== 1'b0 || op_count_out !== 16'd0) begin n_mis++; $display("FAIL clear_alone: got sticky=%b count=%0d want sticky=0 count=0", vf_sticky_out, op_count_out); end
    res_ready_in = 1'b0;
    drive(1'b1, 8'h90, 3'd4, 3'd0);
    step();
    drive(1'b0, 8'h00, 3'd0, 3'd0);
    step();
    n_cmp++; if (res_valid_out !== 1'b1 || vf_out !== 1'b1) begin n_mis++; $display("FAIL clr_xfer_setup: got v=%b vf=%b want v=1 vf=1", res_valid_out, vf_out); end
    res_ready_in = 1'b1; clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    n_cmp++; if (vf_sticky_out !== 1'b1) begin n_mis++; $display("FAIL clr_xfer_sticky: got %b want 1", vf_sticky_out); end
    n_cmp++; if (op_count_out !== 16'd1) begin n_mis++; $display("FAIL clr_xfer_count: got %0d want 1", op_count_out); end
  endtask

  task automatic test_mid_reset();
    res_ready_in = 1'b0;
    drive(1'b1, 8'h05, 3'd1, 3'd0);
    step();
    drive(1'b1, 8'h06, 3'd1, 3'd0);
    step();
    n_cmp++; if (res_valid_out !== 1'b1 || cmd_ready_out !== 1'b0) begin n_mis++; $display("FAIL mrst_full: got v=%b rdy=%b want v=1 rdy=0", res_valid_out, cmd_ready_out); end
    rst_in = 1'b1; res_ready_in = 1'b1; clr_in = 1'b1;
    drive(1'b1, 8'h77, 3'd3, 3'd2);
    step();
    rst_in = 1'b0; res_ready_in = 1'b0; clr_in = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 3'd0);
    n_cmp++; if (res_valid_out !== 1'b0) begin n_mis++; $display("FAIL mrst_valid: got %b want 0", res_valid_out); end
    n_cmp++; if (cmd_ready_out !== 1'b1) begin n_mis++; $display("FAIL mrst_ready: got %b want 1", cmd_ready_out); end
    n_cmp++; if (op_count_out !== 16'd0 || vf_sticky_out !== 1'b0) begin n_mis++; $display("FAIL mrst_stats: got count=%0d sticky=%b want 0/0", op_count_out, vf_sticky_out); end
    n_cmp++; if (sh_x_out !== 8'h00 || y_out !== 8'h00) begin n_mis++; $display("FAIL mrst_data: got sh_x=%h y=%h want 00/00", sh_x_out, y_out); end
  endtask

  task automatic test_wrap();
    int not_ready = 0;
    res_ready_in = 1'b1;
    drive(1'b1, 8'h01, 3'd0, 3'd0);
    for (int i = 0; i < 65535; i++) begin
      if (cmd_ready_out !== 1'b1) not_ready++;
      step();
    end
    drive(1'b0, 8'h00, 3'd0, 3'd0);
    n_cmp++; if (not_ready !== 0) begin n_mis++; $display("FAIL wrap_stream_ready: got %0d stalls want 0", not_ready); end
    step(); step(); step();
    n_cmp++; if (op_count_out !== 16'hFFFF) begin n_mis++; $display("FAIL wrap_preload: got %h want ffff", op_count_out); end
    drive(1'b1, 8'h01, 3'd0, 3'd0);
    step();
    drive(1'b0, 8'h00, 3'd0, 3'd0);
    step(); step();
    n_cmp++; if (op_count_out !== 16'h0000) begin n_mis++; $display("FAIL wrap_rollover: got %h want 0000", op_count_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_sticky_clear();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
